// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl
// Purpose : Shift-register scoreboard giving per-operand forwarding selects,
//           load-use stall and decode-stage write enables. Optional macro
//           HAZ_PERF_CNT_EN adds saturating stall_cnt / fwd_cnt counters.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int NSRC     = 2,
    parameter int SELW     = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hold,
    input  logic                   flush,
    input  logic                   id_valid,
    input  logic                   id_regwrite,
    input  logic                   id_memread,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic [NSRC*REG_AW-1:0] id_src,
    input  logic [NSRC-1:0]        id_src_used,
    output logic [NSRC*SELW-1:0]   fwd_sel,
    output logic                   stall,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ctrl_zero
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0]            stall_cnt,
    output logic [15:0]            fwd_cnt
`endif
);

    logic [DEPTH:1]    sb_valid;
    logic [DEPTH:1]    sb_regwrite;
    logic [DEPTH:1]    sb_memread;
    logic [REG_AW-1:0] sb_rd [1:DEPTH];
    logic [NSRC-1:0]   blocked;
    logic              accept;

    always_comb begin
        fwd_sel = '0;
        blocked = '0;
        for (int i = 0; i < NSRC; i++) begin
            // Scan oldest to youngest so the youngest producer is the final write.
            for (int k = DEPTH; k >= 1; k--) begin
                if (id_valid && id_src_used[i] && sb_valid[k] && sb_regwrite[k] &&
                    (sb_rd[k] == id_src[i*REG_AW +: REG_AW]) && (sb_rd[k] != '0)) begin
                    fwd_sel[i*SELW +: SELW] = SELW'(k);
                    blocked[i]              = sb_memread[k] && (k <= LOAD_LAT);
                end
            end
        end
    end

    assign stall      = id_valid & (|blocked);
    assign pc_write   = ~stall & ~hold;
    assign ifid_write = ~stall & ~hold;
    assign ctrl_zero  = stall | flush;
    assign accept     = id_valid & ~stall & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_valid    <= '0;
            sb_regwrite <= '0;
            sb_memread  <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                sb_rd[k] <= '0;
            end
        end else if (!hold) begin
            sb_valid[DEPTH:2]    <= sb_valid[DEPTH-1:1];
            sb_regwrite[DEPTH:2] <= sb_regwrite[DEPTH-1:1];
            sb_memread[DEPTH:2]  <= sb_memread[DEPTH-1:1];
            for (int k = DEPTH; k >= 2; k--) begin
                sb_rd[k] <= sb_rd[k-1];
            end
            sb_valid[1]    <= accept;
            sb_regwrite[1] <= accept & id_regwrite;
            sb_memread[1]  <= accept & id_memread;
            sb_rd[1]       <= accept ? id_rd : '0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (!hold) begin
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (!stall && id_valid && (|fwd_sel) && (fwd_cnt != 16'hFFFF)) begin
                fwd_cnt <= fwd_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_hazard_ctrl
// Purpose : Directed vector table, reset-mid-stall sequence and randomized
//           traffic checked against an instruction-history reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int REG_AW   = 5;
    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 1;
    localparam int NSRC     = 2;
    localparam int SELW     = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   hold, flush, id_valid, id_regwrite, id_memread;
    logic [REG_AW-1:0]      id_rd;
    logic [NSRC*REG_AW-1:0] id_src;
    logic [NSRC-1:0]        id_src_used;
    logic [NSRC*SELW-1:0]   fwd_sel;
    logic                   stall, pc_write, ifid_write, ctrl_zero;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0]            stall_cnt, fwd_cnt;
    int                     m_scnt, m_fcnt;
`endif

    pipe_hazard_ctrl #(
        .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .NSRC(NSRC), .SELW(SELW)
    ) dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_rd(id_rd), .id_src(id_src), .id_src_used(id_src_used),
        .fwd_sel(fwd_sel), .stall(stall), .pc_write(pc_write),
        .ifid_write(ifid_write), .ctrl_zero(ctrl_zero)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Each entry is one instruction that left ID; index 0 is the youngest (EX).
    typedef struct packed {
        logic       v;
        logic       rw;
        logic       mr;
        logic [4:0] rd;
    } item_t;

    // ctl = {hold, flush, id_valid, id_regwrite, id_memread}; flags = {stall, pc_write, ctrl_zero}
    typedef struct packed {
        logic [4:0] ctl;
        logic [4:0] rd;
        logic [4:0] s1;
        logic [4:0] s0;
        logic [1:0] used;
        logic [2:0] flags;
        logic [1:0] ef1;
        logic [1:0] ef0;
    } vec_t;

    item_t      hist[$];
    vec_t       tbl[19];
    int         n_cmp = 0;
    int         n_fail = 0;
    logic       m_stall, m_pcw, m_cz;
    logic [3:0] m_fwd;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        item_t b;
        b = '0;
        hist.delete();
        for (int k = 0; k < DEPTH; k++) hist.push_back(b);
`ifdef HAZ_PERF_CNT_EN
        m_scnt = 0;
        m_fcnt = 0;
`endif
    endtask

    // Expected outputs from the current in-flight history and ID inputs.
    task automatic model_eval();
        logic        any_block;
        int          best;
        logic [4:0]  s;
        any_block = 1'b0;
        m_fwd     = '0;
        for (int i = 0; i < NSRC; i++) begin
            best = 0;
            s    = id_src[i*REG_AW +: REG_AW];
            for (int k = 1; k <= DEPTH; k++) begin
                if (id_valid && id_src_used[i] && s != 5'd0 &&
                    hist[k-1].v && hist[k-1].rw && hist[k-1].rd == s) begin
                    best = k;
                    break;
                end
            end
            m_fwd[i*SELW +: SELW] = 2'(best);
            if (best != 0 && hist[best-1].mr && best <= LOAD_LAT) any_block = 1'b1;
        end
        m_stall = id_valid & any_block;
        m_pcw   = !m_stall && !hold;
        m_cz    = m_stall || flush;
    endtask

    task automatic apply(input logic [4:0] ctl, input logic [4:0] rd,
                         input logic [9:0] src, input logic [1:0] used, input string tag);
        @(negedge clk);
        {hold, flush, id_valid, id_regwrite, id_memread} = ctl;
        id_rd       = rd;
        id_src      = src;
        id_src_used = used;
        #1;
        model_eval();
        chk({tag, " stall"},      int'(stall),      int'(m_stall));
        chk({tag, " pc_write"},   int'(pc_write),   int'(m_pcw));
        chk({tag, " ifid_write"}, int'(ifid_write), int'(m_pcw));
        chk({tag, " ctrl_zero"},  int'(ctrl_zero),  int'(m_cz));
        if (!m_stall) chk({tag, " fwd_sel"}, int'(fwd_sel), int'(m_fwd));
`ifdef HAZ_PERF_CNT_EN
        chk({tag, " stall_cnt"}, int'(stall_cnt), m_scnt);
        chk({tag, " fwd_cnt"},   int'(fwd_cnt),   m_fcnt);
`endif
    endtask

    task automatic advance();
        item_t n;
        @(posedge clk);
        if (!hold) begin
            n = '0;
            if (id_valid && !m_stall && !flush) begin
                n.v  = 1'b1;
                n.rw = id_regwrite;
                n.mr = id_memread;
                n.rd = id_rd;
            end
            hist.push_front(n);
            void'(hist.pop_back());
`ifdef HAZ_PERF_CNT_EN
            if (m_stall && m_scnt < 16'hFFFF) m_scnt++;
            if (!m_stall && id_valid && m_fwd != 4'd0 && m_fcnt < 16'hFFFF) m_fcnt++;
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [4:0] ctl;
        string      tag;

        tbl[0]  = '{5'b00000, 5'd0,  5'd0, 5'd0,  2'b00, 3'b010, 2'd0, 2'd0};
        tbl[1]  = '{5'b00110, 5'd3,  5'd0, 5'd0,  2'b00, 3'b010, 2'd0, 2'd0};
        tbl[2]  = '{5'b00110, 5'd6,  5'd0, 5'd3,  2'b01, 3'b010, 2'd0, 2'd1};
        tbl[3]  = '{5'b00100, 5'd0,  5'd3, 5'd0,  2'b10, 3'b010, 2'd2, 2'd0};
        tbl[4]  = '{5'b00111, 5'd4,  5'd0, 5'd0,  2'b00, 3'b010, 2'd0, 2'd0};
        tbl[5]  = '{5'b00110, 5'd7,  5'd0, 5'd4,  2'b01, 3'b101, 2'd0, 2'd0};
        tbl[6]  = '{5'b00110, 5'd7,  5'd0, 5'd4,  2'b01, 3'b010, 2'd0, 2'd2};
        tbl[7]  = '{5'b00110, 5'd5,  5'd0, 5'd0,  2'b00, 3'b010, 2'd0, 2'd0};
        tbl[8]  = '{5'b00110, 5'd5,  5'd0, 5'd0,  2'b00, 3'b010, 2'd0, 2'd0};
        tbl[9]  = '{5'b00110, 5'd0,  5'd0, 5'd5,  2'b11, 3'b010, 2'd0, 2'd1};
        tbl[10] = '{5'b00100, 5'd0,  5'd0, 5'd0,  2'b11, 3'b010, 2'd0, 2'd0};
        tbl[11] = '{5'b00111, 5'd8,  5'd0, 5'd0,  2'b00, 3'b010, 2'd0, 2'd0};
        tbl[12] = '{5'b10110, 5'd9,  5'd8, 5'd0,  2'b10, 3'b101, 2'd0, 2'd0};
        tbl[13] = '{5'b10110, 5'd9,  5'd8, 5'd0,  2'b10, 3'b101, 2'd0, 2'd0};
        tbl[14] = '{5'b10110, 5'd9,  5'd8, 5'd0,  2'b10, 3'b101, 2'd0, 2'd0};
        tbl[15] = '{5'b00110, 5'd9,  5'd8, 5'd0,  2'b10, 3'b101, 2'd0, 2'd0};
        tbl[16] = '{5'b00110, 5'd9,  5'd8, 5'd0,  2'b10, 3'b010, 2'd2, 2'd0};
        tbl[17] = '{5'b01110, 5'd10, 5'd0, 5'd0,  2'b00, 3'b011, 2'd0, 2'd0};
        tbl[18] = '{5'b00100, 5'd0,  5'd9, 5'd10, 2'b11, 3'b010, 2'd2, 2'd0};

        reset = 1'b0;
        {hold, flush, id_valid, id_regwrite, id_memread} = 5'b0;
        id_rd = '0; id_src = '0; id_src_used = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Directed vectors: hand expectations plus the reference model.
        for (int r = 0; r < 19; r++) begin
            tag = $sformatf("vec%0d", r);
            apply(tbl[r].ctl, tbl[r].rd, {tbl[r].s1, tbl[r].s0}, tbl[r].used, tag);
            chk({tag, " exp stall"},     int'(stall),     int'(tbl[r].flags[2]));
            chk({tag, " exp pc_write"},  int'(pc_write),  int'(tbl[r].flags[1]));
            chk({tag, " exp ctrl_zero"}, int'(ctrl_zero), int'(tbl[r].flags[0]));
            if (!tbl[r].flags[2])
                chk({tag, " exp fwd_sel"}, int'(fwd_sel), int'({tbl[r].ef1, tbl[r].ef0}));
            advance();
        end

        // Asynchronous reset while a load-use stall is pending.
        apply(5'b00111, 5'd4, 10'd0, 2'b00, "rst_lw");
        advance();
        apply(5'b00110, 5'd7, {5'd0, 5'd4}, 2'b01, "rst_use");
        chk("rst_use pending stall", int'(stall), 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_async stall",     int'(stall),      0);
        chk("rst_async fwd_sel",   int'(fwd_sel),    0);
        chk("rst_async pc_write",  int'(pc_write),   1);
        chk("rst_async ifid",      int'(ifid_write), 1);
        chk("rst_async ctrl_zero", int'(ctrl_zero),  0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_rel stall",    int'(stall),    0);
        chk("rst_rel fwd_sel",  int'(fwd_sel),  0);
        chk("rst_rel pc_write", int'(pc_write), 1);
        id_valid = 1'b0;
        @(posedge clk);

        // Randomized traffic over a small register range to provoke hazards.
        for (int c = 0; c < 3000; c++) begin
            ctl[4] = ($urandom_range(0, 7) == 0);
            ctl[3] = ($urandom_range(0, 7) == 0);
            ctl[2] = ($urandom_range(0, 3) != 0);
            ctl[1] = ($urandom_range(0, 3) != 0);
            ctl[0] = ($urandom_range(0, 2) == 0);
            apply(ctl, 5'($urandom_range(0, 7)),
                  {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
                  2'($urandom_range(0, 3)), $sformatf("rnd%0d", c));
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
